// File: rtl/demux_14_pkg.sv
// Shared types and constants for the demux_14 lane router.
package demux_14_pkg;
  localparam int LANES = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [LANES-1:0] lane_mask_t;

  function automatic lane_mask_t sel_onehot(input sel_t sel);
    lane_mask_t m;
    m = '0;
    m[sel] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/demux_14_dec.sv
// Combinational 2-to-4 one-hot lane decode, gated by the transfer enable.
module demux_14_dec
  import demux_14_pkg::*;
(
  input  logic [SEL_W-1:0] s,
  input  logic             en,
  output lane_mask_t       mask
);

  // With en low the select is never looked at, so X on s cannot leak through.
  always_comb begin
    mask = '0;
    if (en) mask = sel_onehot(s);
  end

endmodule

// File: rtl/demux_14.sv
// Registered 1-to-4 demultiplexer with one-hot lane valids.
// Optional per-lane saturating transfer counters: define DEMUX14_STATS_EN.
module demux_14
  import demux_14_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEL_W-1:0]        s,
  input  logic [DATA_W-1:0]       din,
  input  logic                    en,
`ifdef DEMUX14_STATS_EN
  input  logic                    cnt_clr,
  output logic [LANES-1:0][CNT_W-1:0] lane_cnt,
`endif
  output logic [LANES*DATA_W-1:0] y,
  output logic [LANES-1:0]        y_valid,
  output logic [SEL_W-1:0]        sel_q
);

  lane_mask_t              mask_d;
  lane_mask_t              y_valid_q;
  logic [LANES*DATA_W-1:0] y_d, y_q;
  logic [SEL_W-1:0]        sel_d;

  demux_14_dec u_dec (
    .s    (s),
    .en   (en),
    .mask (mask_d)
  );

  always_comb begin
    y_d = '0;
    for (int k = 0; k < LANES; k++) begin
      if (mask_d[k]) y_d[k*DATA_W +: DATA_W] = din;
    end
  end

  assign sel_d = en ? s : sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= '0;
      sel_q     <= '0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= mask_d;
      sel_q     <= sel_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;

`ifdef DEMUX14_STATS_EN
  // Clear wins over a same-cycle transfer; counts stick at all-ones.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (rst || cnt_clr) begin
        lane_cnt[k] <= '0;
      end else if (mask_d[k] && (lane_cnt[k] != '1)) begin
        lane_cnt[k] <= lane_cnt[k] + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux_14.sv
// Directed self-checking bench for demux_14 (DATA_W=1 and DATA_W=8 instances).
module tb_demux_14;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] s;
  logic       din1;
  logic [7:0] din8;
  logic       en;
  logic [3:0]  y1;
  logic [31:0] y8;
  logic [3:0]  yv1, yv8;
  logic [1:0]  sel1, sel8;
`ifdef DEMUX14_STATS_EN
  logic        cnt_clr;
  logic [3:0][7:0] cnt1, cnt8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_14 #(.DATA_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .s(s), .din(din1), .en(en),
`ifdef DEMUX14_STATS_EN
    .cnt_clr(cnt_clr), .lane_cnt(cnt1),
`endif
    .y(y1), .y_valid(yv1), .sel_q(sel1)
  );

  demux_14 #(.DATA_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .s(s), .din(din8), .en(en),
`ifdef DEMUX14_STATS_EN
    .cnt_clr(cnt_clr), .lane_cnt(cnt8),
`endif
    .y(y8), .y_valid(yv8), .sel_q(sel8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic [3:0] exp_y,
                        input logic [3:0] exp_v, input logic [1:0] exp_sel);
    checks++;
    if (y1 !== exp_y || yv1 !== exp_v || sel1 !== exp_sel) begin
      errors++;
      $display("FAIL %s: y=%h y_valid=%b sel_q=%0d, expected y=%h y_valid=%b sel_q=%0d",
               name, y1, yv1, sel1, exp_y, exp_v, exp_sel);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; s = 2'd0; din1 = 1'b0; din8 = 8'h00;
`ifdef DEMUX14_STATS_EN
    cnt_clr = 1'b0;
`endif
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; s = 2'd3; din1 = 1'b1; din8 = 8'hFF;
`ifdef DEMUX14_STATS_EN
    cnt_clr = 1'b0;
`endif
    step();
    do_reset();
    check1("reset", 4'h0, 4'b0000, 2'd0);
  endtask

  task automatic test_sweep();
    logic [3:0] exp_y [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s = 2'(i); din1 = 1'b1; en = 1'b1;
      step();
      check1($sformatf("sweep_s%0d", i), exp_y[i], exp_y[i], 2'(i));
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4] = '{2'd3, 2'd0, 2'd2, 2'd1};
    logic [3:0] exp [4] = '{4'h8, 4'h1, 4'h4, 4'h2};
    for (int i = 0; i < 4; i++) begin
      s = seq[i]; din1 = 1'b1; en = 1'b1;
      step();
      check1($sformatf("b2b_%0d", i), exp[i], exp[i], seq[i]);
      checks++;
      if ($countones(yv1) != 1) begin
        errors++;
        $display("FAIL b2b_onehot_%0d: y_valid=%b, expected exactly one bit set", i, yv1);
      end
    end
  endtask

  task automatic test_disable();
    s = 2'd2; din1 = 1'b1; en = 1'b0;
    step();
    check1("disable", 4'h0, 4'b0000, 2'd1);
  endtask

  task automatic test_zero_data();
    s = 2'd3; din1 = 1'b0; en = 1'b1;
    step();
    check1("zero_data", 4'h0, 4'b1000, 2'd3);
  endtask

  task automatic test_wide();
    s = 2'd1; din8 = 8'hA5; en = 1'b1;
    step();
    checks++;
    if (y8 !== 32'h0000_A500 || yv8 !== 4'b0010) begin
      errors++;
      $display("FAIL wide_s1: y=%h y_valid=%b, expected y=0000a500 y_valid=0010", y8, yv8);
    end
    s = 2'd3; din8 = 8'h3C;
    step();
    checks++;
    if (y8 !== 32'h3C00_0000 || yv8 !== 4'b1000 || sel8 !== 2'd3) begin
      errors++;
      $display("FAIL wide_s3: y=%h y_valid=%b sel_q=%0d, expected y=3c000000 y_valid=1000 sel_q=3",
               y8, yv8, sel8);
    end
  endtask

  task automatic test_reset_priority();
    s = 2'd1; din1 = 1'b1; en = 1'b1;
    step();
    check1("pre_rst", 4'h2, 4'b0010, 2'd1);
    rst = 1'b1; s = 2'd3; din1 = 1'b1; en = 1'b1;
    step();
    check1("rst_priority", 4'h0, 4'b0000, 2'd0);
    rst = 1'b0; en = 1'b0;
    step();
    check1("rst_no_residue", 4'h0, 4'b0000, 2'd0);
  endtask

  task automatic test_post_reset();
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0; s = 2'd2; din1 = 1'b1; en = 1'b1;
    step();
    check1("first_after_rst", 4'h4, 4'b0100, 2'd2);
  endtask

  task automatic test_x_sel();
    s = 2'd2; din1 = 1'b1; en = 1'b1;
    step();
    s = 2'bxx; din1 = 1'bx; en = 1'b0;
    step();
    check1("x_sel_disabled", 4'h0, 4'b0000, 2'd2);
  endtask

`ifdef DEMUX14_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++;
    if (cnt1 !== '0) begin
      errors++;
      $display("FAIL stats_reset: lane_cnt=%h, expected 0", cnt1);
    end
    s = 2'd0; din1 = 1'b1; en = 1'b1;
    for (int i = 0; i < 254; i++) step();
    checks++;
    if (cnt1[0] !== 8'd254) begin
      errors++;
      $display("FAIL stats_254: lane_cnt[0]=%0d, expected 254", cnt1[0]);
    end
    for (int i = 0; i < 46; i++) step();
    checks++;
    if (cnt1[0] !== 8'd255 || cnt1[3:1] !== '0) begin
      errors++;
      $display("FAIL stats_sat: lane_cnt=%h, expected 000000ff", cnt1);
    end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0; en = 1'b0;
    checks++;
    if (cnt1 !== '0) begin
      errors++;
      $display("FAIL stats_clr: lane_cnt=%h, expected 0", cnt1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_back_to_back();
    test_disable();
    test_zero_data();
    test_wide();
    test_reset_priority();
    test_post_reset();
    test_x_sel();
`ifdef DEMUX14_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
